// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the control unit.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;

  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from ALUOp and instruction fields.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only register-register ops use bit 30 to select subtract.
          3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V core (lw/sw/R/I/beq/jal).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.slave  bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_adrsrc;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_illegal;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  aluop_t     w_aluop;
  logic [2:0] w_alucontrol;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_resultsrc = RES_ALUOUT;
    w_alusrca   = SRCA_PC;
    w_alusrcb   = SRCB_RD2;
    w_aluop     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_alusrcb   = SRCB_FOUR;
        w_resultsrc = RES_ALURESULT;
        w_pcupdate  = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alusrca = SRCA_OLDPC;
        w_alusrcb = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTER;
          OP_ITYPE:     w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = SRCA_RD1;
        w_alusrcb = SRCB_IMM;
        w_next    = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = RES_DATA;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        w_alusrca = SRCA_RD1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alusrca = SRCA_RD1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BEQ: begin
        w_alusrca = SRCA_RD1;
        w_aluop   = ALUOP_SUB;
        w_branch  = 1'b1;
      end
      S_JAL: begin
        w_alusrca  = SRCA_OLDPC;
        w_alusrcb  = SRCB_FOUR;
        w_pcupdate = 1'b1;
        w_next     = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (w_aluop),
    .funct3     (bus.funct3),
    .op5        (bus.op[5]),
    .funct7b5   (bus.funct7b5),
    .ALUControl (w_alucontrol)
  );

  // State-changing enables are gated by reset so nothing commits while it is held.
  assign bus.PCWrite    = ~rst & (w_pcupdate | (w_branch & bus.zero));
  assign bus.MemWrite   = ~rst & w_memwrite;
  assign bus.IRWrite    = ~rst & w_irwrite;
  assign bus.RegWrite   = ~rst & w_regwrite;
  assign bus.illegal    = ~rst & w_illegal;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.ResultSrc  = w_resultsrc;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ImmSrc     = imm_src(bus.op);
  assign bus.ALUControl = w_alucontrol;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle check of every control output of multicycle_ctrl.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compares all outputs at once: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
  task automatic chk(input string tag, input logic pcw, input logic adr, input logic mw,
                     input logic irw, input logic rw, input logic [1:0] rs,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
                     input logic [2:0] alu, input logic ill);
    logic [16:0] obs;
    logic [16:0] expv;
    #1;
    obs  = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.illegal};
    expv = {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  initial begin
    rst = 1'b1;
    bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    step();
    chk("rst_fetch_forced", 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);

    // lw: 5 cycles
    rst = 1'b0;
    chk("lw_fetch",   1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    step(); chk("lw_decode",  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0);
    step(); chk("lw_memadr",  0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    step(); chk("lw_memread", 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    step(); chk("lw_memwb",   0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);

    // sw: 4 cycles
    step(); bus.op = 7'b0100011;
    chk("sw_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    step(); chk("sw_decode",   0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0);
    step(); chk("sw_memadr",   0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
    step(); chk("sw_memwrite", 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);

    // sub (zero held high to show it only matters in BEQ)
    step(); bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1; bus.zero = 1'b1;
    chk("sub_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    step(); chk("sub_decode",   0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0);
    step(); chk("sub_executer", 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
    step(); chk("sub_aluwb",    0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);

    // add
    step(); bus.funct7b5 = 1'b0;
    chk("add_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    step(); step();
    chk("add_executer", 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0);
    step();

    // and
    step(); bus.funct3 = 3'b111;
    step(); step();
    chk("and_executer", 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 0);
    step();

    // slti
    step(); bus.op = 7'b0010011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    step(); step();
    chk("slti_executei", 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101, 0);
    step(); chk("slti_aluwb",    0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);

    // addi with bit 30 set must still add
    step(); bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    step(); step();
    chk("addi_b30_executei", 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    step();

    // beq taken: 3 cycles
    step(); bus.op = 7'b1100011; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
    chk("beq_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    step(); chk("beq_decode",   0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0);
    step(); chk("beq_taken",    1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);

    // beq not taken
    step(); bus.zero = 1'b0;
    chk("beq_nt_fetch", 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    step(); step();
    chk("beq_not_taken", 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);

    // jal: 4 cycles
    step(); bus.op = 7'b1101111;
    chk("jal_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0);
    step(); step();
    chk("jal_jal",      1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
    step(); chk("jal_aluwb",    0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0);

    // illegal opcode: 2 cycles
    step(); bus.op = 7'b0000000;
    chk("ill_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    step(); chk("ill_decode",   0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1);
    step(); chk("ill_refetch",  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);

    // reset asserted during MEMWRITE
    bus.op = 7'b0100011;
    step(); step(); step();
    rst = 1'b1;
    chk("rst_memwrite_forced", 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
    step(); chk("rst_held_fetch",  0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    rst = 1'b0;
    chk("rst_release_fetch",       1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    step(); chk("rst_release_decode", 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 op  input  7  opcode from instruction register.
REQ-004 funct3  input  3  instruction bits [14:12].
REQ-005 funct7b5  input  1  instruction bit 30.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 PCWrite  output  1  PC register enable.
REQ-008 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-009 MemWrite  output  1  data memory write enable.
REQ-010 IRWrite  output  1  instruction/OldPC register enable.
REQ-011 RegWrite  output  1  register-file write enable.
REQ-012 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALU result.
REQ-013 ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1.
REQ-014 ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4.
REQ-015 ImmSrc  output  2  00=I, 01=S, 10=B, 11=J; decoded combinationally from op.
REQ-016 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-017 illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; unlisted outputs are 0 in each state.
REQ-019 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1; next DECODE.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, other -> FETCH with illegal=1.
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-022 MEMREAD: ResultSrc=00, AdrSrc=1; next MEMWB.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-024 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1; next FETCH.
REQ-025 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both next ALUWB.
REQ-026 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-027 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; next FETCH.
REQ-028 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next ALUWB.
REQ-029 PCWrite SHALL equal PCUpdate OR (Branch AND zero), combinational on the current zero.
REQ-030 ALU decode: ALUOp=00 -> 000; 01 -> 001; 10 by funct3: 000 -> 001 if op[5] AND funct7b5 else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
REQ-031 Instruction latency SHALL be: lw 5 cycles, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, illegal 2 (FETCH to FETCH inclusive).
REQ-032 ImmSrc: op 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.

Reset
REQ-033 While rst=1, PCWrite, MemWrite, IRWrite, RegWrite and illegal SHALL be forced 0 and state SHALL load FETCH on the clock edge.
REQ-034 Reset asserted in any state, including mid-instruction, SHALL abandon the instruction; the first cycle after rst deasserts SHALL be FETCH.

Structure
REQ-035 A shared package SHALL hold the state enum, ALUControl codes, opcode constants and the ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings.
REQ-036 The ALU decode SHALL be the combinational sub-module alu_decoder (inputs ALUOp, funct3, op5, funct7b5; output ALUControl).

Verification
REQ-037 lw (op=0000011) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5 only; MemWrite never 1.
REQ-038 sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; add (funct7b5=0) -> 000; slti (op=0010011, funct3=010) -> 101.
REQ-039 beq with zero=1 -> PCWrite=1 in cycle 3; zero=0 -> PCWrite=0 in cycle 3; return to FETCH in both cases.
REQ-040 sw (op=0100011) -> ImmSrc=01, MemWrite=1 with AdrSrc=1 in cycle 4; RegWrite never 1.
REQ-041 op=0000000 -> illegal=1 in cycle 2 for one cycle, then FETCH; no MemWrite or RegWrite.
REQ-042 rst=1 during MEMWRITE -> MemWrite=0 in that cycle; FETCH on the first cycle after rst deasserts.
